// File: rtl/action_executor_pkg.sv
// action_executor_pkg: shared widths, action record layout, opcode and FSM types
package action_executor_pkg;
    localparam int BYTE_BUS     = 8;
    localparam int DATA_BUS     = 8;
    localparam int HDR_MAX_LEN  = 32;
    localparam int MAX_VAL_LEN  = 8;
    localparam int NUM_HEADERS  = 4;

    localparam int ACT_OP_IDX   = 0;
    localparam int ACT_HDR_IDX  = 1;
    localparam int ACT_OFF_IDX  = 2;
    localparam int ACT_LEN_IDX  = 3;
    localparam int ACT_DATA_IDX = 4;

    localparam int MAX_DATA_LEN = MAX_VAL_LEN - ACT_DATA_IDX;
    localparam int LEN_W        = $clog2(MAX_DATA_LEN + 1);
    localparam int VIDX_W       = $clog2(MAX_VAL_LEN);
    localparam int HIDX_W       = $clog2(HDR_MAX_LEN);
    localparam int HID_W        = $clog2(NUM_HEADERS);
    localparam int ADDR_W       = DATA_BUS + 2;

    typedef enum logic [7:0] {
        ACT_NOP  = 8'd0,
        ACT_SET  = 8'd1,
        ACT_ADD  = 8'd2,
        ACT_FWD  = 8'd3,
        ACT_DROP = 8'd4
    } act_op_e;

    typedef enum logic [1:0] {ST_FREE, ST_DECODE, ST_WRITE, ST_DONE} state_e;

    typedef logic [MAX_VAL_LEN-1:0][BYTE_BUS-1:0] val_t;
    typedef logic [HDR_MAX_LEN-1:0][BYTE_BUS-1:0] hdr_t;
    typedef logic [NUM_HEADERS-1:0][DATA_BUS-1:0] offs_t;
endpackage

// File: rtl/action_executor_if.sv
// action_executor_if: matcher-side handshake, header bus and verdict outputs (stats with EXECUTOR_STATS_EN)
interface action_executor_if;
    import action_executor_pkg::*;
    logic        start_i;
    logic        is_match_i;
    val_t        flow_val_i;
    hdr_t        pkt_hdr_i;
    offs_t       parsed_hdrs_i;
    hdr_t        pkt_hdr_o;
    logic [7:0]  egress_port_o;
    logic        drop_o;
    logic        err_o;
    logic [7:0]  err_proc_o;
    logic        ready_o;
    logic        mod_start_i;
    logic [7:0]  mod_miss_op_i;
    logic [7:0]  mod_miss_port_i;
`ifdef EXECUTOR_STATS_EN
    logic [31:0] stat_hit_o;
    logic [31:0] stat_miss_o;
    logic [31:0] stat_drop_o;
`endif

    modport master (
        output start_i, is_match_i, flow_val_i, pkt_hdr_i, parsed_hdrs_i,
               mod_start_i, mod_miss_op_i, mod_miss_port_i,
        input  pkt_hdr_o, egress_port_o, drop_o, err_o, err_proc_o, ready_o
`ifdef EXECUTOR_STATS_EN
        , input stat_hit_o, stat_miss_o, stat_drop_o
`endif
    );

    modport slave (
        input  start_i, is_match_i, flow_val_i, pkt_hdr_i, parsed_hdrs_i,
               mod_start_i, mod_miss_op_i, mod_miss_port_i,
        output pkt_hdr_o, egress_port_o, drop_o, err_o, err_proc_o, ready_o
`ifdef EXECUTOR_STATS_EN
        , output stat_hit_o, stat_miss_o, stat_drop_o
`endif
    );
endinterface

// File: rtl/action_executor_alu_byte.sv
// action_alu_byte: one byte step of SET (pass data) or ADD (old + data + carry)
module action_alu_byte
    import action_executor_pkg::*;
(
    input  act_op_e    op,
    input  logic [7:0] old_byte,
    input  logic [7:0] data_byte,
    input  logic       carry_in,
    output logic [7:0] new_byte,
    output logic       carry_out
);
    logic [8:0] sum;
    assign sum       = {1'b0, old_byte} + {1'b0, data_byte} + {8'd0, carry_in};
    assign new_byte  = op == ACT_ADD ? sum[7:0] : data_byte;
    assign carry_out = op == ACT_ADD && sum[8];
endmodule

// File: rtl/action_executor.sv
// action_executor: executes a matched flow action record on the header buffer; optional counters via EXECUTOR_STATS_EN
module action_executor
    import action_executor_pkg::*;
#(
    parameter int PROC_ID = 0
) (
    input logic clk,
    input logic rst,
    action_executor_if.slave bus
);
    state_e              state;
    hdr_t                buf_r, hdr_out;
    val_t                val_r;
    offs_t               hdrs_r;
    logic                hit_r, carry_r, drop_r, err_r, ready_r;
    act_op_e             op_r;
    logic [ADDR_W-1:0]   base_r;
    logic [LEN_W-1:0]    len_r, cnt_r;
    logic [7:0]          miss_op_r, miss_port_r, egress_r;

    logic [7:0]          raw_op;
    logic                known, clamp, in_rng, carry_out;
    act_op_e             dec_op;
    logic [LEN_W-1:0]    dec_len, idx;
    logic [HID_W-1:0]    hid;
    logic [ADDR_W-1:0]   dec_base, addr;
    logic [VIDX_W-1:0]   dsel;
    logic [7:0]          old_byte, new_byte;

    // Decode of the latched record and address of the byte handled this WRITE cycle
    always_comb begin
        raw_op   = hit_r ? val_r[ACT_OP_IDX] : miss_op_r;
        known    = raw_op <= 8'(ACT_DROP);
        dec_op   = known ? act_op_e'(raw_op) : ACT_NOP;
        clamp    = val_r[ACT_LEN_IDX] > 8'(MAX_DATA_LEN);
        dec_len  = clamp ? LEN_W'(MAX_DATA_LEN) : LEN_W'(val_r[ACT_LEN_IDX]);
        hid      = val_r[ACT_HDR_IDX] < 8'(NUM_HEADERS) ? HID_W'(val_r[ACT_HDR_IDX]) : '0;
        dec_base = ADDR_W'(hdrs_r[hid]) + ADDR_W'(val_r[ACT_OFF_IDX]);
        idx      = op_r == ACT_ADD ? len_r - cnt_r - LEN_W'(1) : cnt_r;
        addr     = base_r + ADDR_W'(idx);
        in_rng   = addr < ADDR_W'(HDR_MAX_LEN);
        old_byte = in_rng ? buf_r[addr[HIDX_W-1:0]] : '0;
        dsel     = VIDX_W'(ACT_DATA_IDX) + VIDX_W'(idx);
    end

    action_alu_byte u_alu (
        .op        (op_r),
        .old_byte  (old_byte),
        .data_byte (val_r[dsel]),
        .carry_in  (carry_r),
        .new_byte  (new_byte),
        .carry_out (carry_out)
    );

    // Control FSM: accept, decode, byte-serial write, publish result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FREE;
            buf_r       <= '0;
            hdr_out     <= '0;
            val_r       <= '0;
            hdrs_r      <= '0;
            hit_r       <= 1'b0;
            carry_r     <= 1'b0;
            drop_r      <= 1'b0;
            err_r       <= 1'b0;
            ready_r     <= 1'b0;
            op_r        <= ACT_NOP;
            base_r      <= '0;
            len_r       <= '0;
            cnt_r       <= '0;
            miss_op_r   <= 8'(ACT_NOP);
            miss_port_r <= '0;
            egress_r    <= '0;
        end else begin
            ready_r <= 1'b0;
            case (state)
                ST_FREE: begin
                    if (bus.mod_start_i) begin
                        miss_op_r   <= bus.mod_miss_op_i;
                        miss_port_r <= bus.mod_miss_port_i;
                    end else if (bus.start_i) begin
                        val_r  <= bus.flow_val_i;
                        hdrs_r <= bus.parsed_hdrs_i;
                        hit_r  <= bus.is_match_i;
                        buf_r  <= bus.pkt_hdr_i;
                        drop_r <= 1'b0;
                        err_r  <= 1'b0;
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    op_r    <= dec_op;
                    len_r   <= dec_len;
                    base_r  <= dec_base;
                    cnt_r   <= '0;
                    carry_r <= 1'b0;
                    if (!known || clamp) err_r <= 1'b1;
                    if (dec_op == ACT_FWD) egress_r <= hit_r ? val_r[ACT_DATA_IDX] : miss_port_r;
                    if (dec_op == ACT_DROP) drop_r <= 1'b1;
                    state <= (dec_op == ACT_SET || dec_op == ACT_ADD) && dec_len != '0 ? ST_WRITE : ST_DONE;
                end
                ST_WRITE: begin
                    if (in_rng) buf_r[addr[HIDX_W-1:0]] <= new_byte;
                    else err_r <= 1'b1;
                    carry_r <= carry_out;
                    cnt_r   <= cnt_r + LEN_W'(1);
                    if (cnt_r == len_r - LEN_W'(1)) state <= ST_DONE;
                end
                default: begin
                    hdr_out <= buf_r;
                    ready_r <= 1'b1;
                    state   <= ST_FREE;
                end
            endcase
        end
    end

    assign bus.pkt_hdr_o     = hdr_out;
    assign bus.egress_port_o = egress_r;
    assign bus.drop_o        = drop_r;
    assign bus.err_o         = err_r;
    assign bus.err_proc_o    = err_r ? 8'(PROC_ID) : 8'd0;
    assign bus.ready_o       = ready_r;

`ifdef EXECUTOR_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, drop_cnt;
    logic        accept;
    assign accept = state == ST_FREE && !bus.mod_start_i && bus.start_i;

    // Saturating hit/miss counters on accepted starts and drop counter on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept && bus.is_match_i && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (accept && !bus.is_match_i && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            if (state == ST_DONE && drop_r && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
        end
    end

    assign bus.stat_hit_o  = hit_cnt;
    assign bus.stat_miss_o = miss_cnt;
    assign bus.stat_drop_o = drop_cnt;
`endif
endmodule

// File: tb/tb_action_executor.sv
// tb_action_executor: directed and random action records checked against a byte-array reference model
module tb_action_executor;
    import action_executor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    action_executor_if bus();
    action_executor #(.PROC_ID(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [7:0] m_miss_op = 8'd0, m_miss_port = 8'd0, m_egress = 8'd0;
    int m_hit = 0, m_miss = 0, m_drop = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic val_t mkrec(input int op, hid, off, len, d0, d1, d2, d3);
        val_t r;
        r[0] = 8'(op); r[1] = 8'(hid); r[2] = 8'(off); r[3] = 8'(len);
        r[4] = 8'(d0); r[5] = 8'(d1); r[6] = 8'(d2); r[7] = 8'(d3);
        return r;
    endfunction

    function automatic hdr_t rnd_hdr;
        hdr_t h;
        for (int i = 0; i < HDR_MAX_LEN; i++) h[i] = 8'($urandom);
        return h;
    endfunction

    task automatic check_stats(input string tag);
`ifdef EXECUTOR_STATS_EN
        check({tag, "_stat_hit"}, 256'(bus.stat_hit_o), 256'(m_hit));
        check({tag, "_stat_miss"}, 256'(bus.stat_miss_o), 256'(m_miss));
        check({tag, "_stat_drop"}, 256'(bus.stat_drop_o), 256'(m_drop));
`else
        if (tag == "") $display("stats disabled");
`endif
    endtask

    task automatic set_miss(input logic [7:0] op, input logic [7:0] port);
        bus.mod_start_i = 1'b1;
        bus.mod_miss_op_i = op;
        bus.mod_miss_port_i = port;
        step;
        bus.mod_start_i = 1'b0;
        m_miss_op = op;
        m_miss_port = port;
    endtask

    // Call at #1 after a rising edge; drives start immediately so calls chain back-to-back
    task automatic run_op(input string tag, input logic m, input val_t rec, input hdr_t hdr,
                          input offs_t ph, input bit inject);
        hdr_t e_hdr = hdr;
        logic e_drop = 1'b0, e_err = 1'b0;
        int op = m ? int'(rec[0]) : int'(m_miss_op);
        int len = rec[3];
        int base = int'(ph[rec[1]]) + int'(rec[2]);
        int e_lat = 2, lat = 0;
        longint ov = 0, dv = 0, sv;
        if (len > MAX_DATA_LEN) begin len = MAX_DATA_LEN; e_err = 1'b1; end
        if (op > 4) begin op = 0; e_err = 1'b1; end
        if (op == 1)
            for (int i = 0; i < len; i++)
                if (base + i < HDR_MAX_LEN) e_hdr[base+i] = rec[4+i]; else e_err = 1'b1;
        if (op == 2) begin
            for (int i = 0; i < len; i++) begin
                ov = (ov << 8) | (base + i < HDR_MAX_LEN ? longint'(hdr[base+i]) : 0);
                dv = (dv << 8) | longint'(rec[4+i]);
            end
            sv = ov + dv;
            for (int i = 0; i < len; i++)
                if (base + i < HDR_MAX_LEN) e_hdr[base+i] = 8'(sv >> (8 * (len - 1 - i))); else e_err = 1'b1;
        end
        if (op == 3) m_egress = m ? rec[4] : m_miss_port;
        if (op == 4) e_drop = 1'b1;
        if ((op == 1 || op == 2) && len > 0) e_lat = len + 2;
        if (m) m_hit++; else m_miss++;
        if (e_drop) m_drop++;

        bus.start_i = 1'b1;
        bus.is_match_i = m;
        bus.flow_val_i = rec;
        bus.pkt_hdr_i = hdr;
        bus.parsed_hdrs_i = ph;
        step;
        bus.start_i = 1'b0;
        bus.is_match_i = 1'($urandom);
        bus.flow_val_i = {$urandom, $urandom};
        bus.pkt_hdr_i = rnd_hdr();
        bus.parsed_hdrs_i = offs_t'($urandom);
        while (1) begin
            if (inject && lat == 1) bus.start_i = 1'b1;
            step;
            bus.start_i = 1'b0;
            lat++;
            if (bus.ready_o) break;
            if (lat > 30) begin
                check({tag, "_ready_timeout"}, 256'(0), 256'(1));
                return;
            end
        end
        check({tag, "_latency"}, 256'(lat), 256'(e_lat));
        check({tag, "_hdr"}, bus.pkt_hdr_o, e_hdr);
        check({tag, "_egress"}, 256'(bus.egress_port_o), 256'(m_egress));
        check({tag, "_drop"}, 256'(bus.drop_o), 256'(e_drop));
        check({tag, "_err"}, 256'(bus.err_o), 256'(e_err));
        check({tag, "_err_proc"}, 256'(bus.err_proc_o), 256'(e_err ? 3 : 0));
        check_stats(tag);
    endtask

    initial begin
        hdr_t h;
        offs_t ph;
        bus.start_i = 1'b0;
        bus.is_match_i = 1'b0;
        bus.flow_val_i = '0;
        bus.pkt_hdr_i = '0;
        bus.parsed_hdrs_i = '0;
        bus.mod_start_i = 1'b0;
        bus.mod_miss_op_i = '0;
        bus.mod_miss_port_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step;

        check("reset_ready", 256'(bus.ready_o), 256'(0));
        check("reset_hdr", bus.pkt_hdr_o, 256'(0));
        check("reset_egress", 256'(bus.egress_port_o), 256'(0));
        check("reset_drop_err", 256'({bus.drop_o, bus.err_o}), 256'(0));
        check_stats("reset");

        ph = '0;
        ph[2] = 8'd14;
        h = rnd_hdr();
        run_op("set", 1'b1, mkrec(1, 2, 2, 2, 'hAB, 'hCD, 0, 0), h, ph, 1'b0);
        check("set_byte16", 256'(bus.pkt_hdr_o[16]), 256'('hAB));
        check("set_byte17", 256'(bus.pkt_hdr_o[17]), 256'('hCD));

        h[16] = 8'h00; h[17] = 8'hFF;
        run_op("add_carry", 1'b1, mkrec(2, 2, 2, 2, 'h00, 'h01, 0, 0), h, ph, 1'b0);
        check("add_carry_val", 256'({bus.pkt_hdr_o[16], bus.pkt_hdr_o[17]}), 256'('h0100));
        h[16] = 8'hFF; h[17] = 8'hFF;
        run_op("add_wrap", 1'b1, mkrec(2, 2, 2, 2, 'h00, 'h01, 0, 0), h, ph, 1'b0);
        check("add_wrap_val", 256'({bus.pkt_hdr_o[16], bus.pkt_hdr_o[17]}), 256'('h0000));

        set_miss(8'd3, 8'd7);
        run_op("miss_fwd", 1'b0, mkrec(1, 2, 2, 2, 1, 2, 3, 4), rnd_hdr(), ph, 1'b0);
        check("miss_fwd_port", 256'(bus.egress_port_o), 256'(7));

        run_op("drop", 1'b1, mkrec(4, 0, 0, 0, 0, 0, 0, 0), rnd_hdr(), ph, 1'b0);
        run_op("b2b_set", 1'b1, mkrec(1, 1, 3, 3, 9, 8, 7, 0), rnd_hdr(), ph, 1'b1);

        ph[0] = 8'd20;
        run_op("ovf", 1'b1, mkrec(1, 0, 11, 3, 'h11, 'h22, 'h33, 0), rnd_hdr(), ph, 1'b0);

        bus.start_i = 1'b1;
        bus.is_match_i = 1'b1;
        bus.flow_val_i = mkrec(1, 2, 2, 4, 1, 2, 3, 4);
        bus.pkt_hdr_i = rnd_hdr();
        step;
        bus.start_i = 1'b0;
        step;
        step;
        rst = 1'b0;
        #1;
        check("rst_mid_ready", 256'(bus.ready_o), 256'(0));
        check("rst_mid_hdr", bus.pkt_hdr_o, 256'(0));
        check("rst_mid_out", 256'({bus.egress_port_o, bus.drop_o, bus.err_o}), 256'(0));
        m_egress = 0; m_miss_op = 0; m_miss_port = 0; m_hit = 0; m_miss = 0; m_drop = 0;
        check_stats("rst_mid");
        @(negedge clk) rst = 1'b1;
        begin
            int seen = 0;
            repeat (8) begin
                step;
                if (bus.ready_o) seen++;
            end
            check("rst_mid_no_ready", 256'(seen), 256'(0));
        end
        run_op("after_rst_hit", 1'b1, mkrec(0, 0, 0, 0, 0, 0, 0, 0), rnd_hdr(), ph, 1'b0);
        run_op("after_rst_miss_nop", 1'b0, mkrec(3, 0, 0, 0, 5, 0, 0, 0), rnd_hdr(), ph, 1'b0);

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(7, 0) == 0) set_miss(8'($urandom_range(5, 0)), 8'($urandom));
            for (int k = 0; k < NUM_HEADERS; k++) ph[k] = 8'($urandom_range(28, 0));
            run_op("rand", 1'($urandom), mkrec($urandom_range(6, 0), $urandom_range(3, 0),
                   $urandom_range(8, 0), $urandom_range(6, 0), $urandom, $urandom, $urandom, $urandom),
                   rnd_hdr(), ph, 1'($urandom));
            if ($urandom_range(3, 0) == 0) begin
                step;
                check("rand_ready_one_cycle", 256'(bus.ready_o), 256'(0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/action_executor.md
Name: action_executor

Overview:
- Stage directly downstream of the flow matcher in each processor.
- Consumes matcher's ready/is_match/flow value and executes the action encoded in the value bytes against the packet header buffer.
- Actions: rewrite header field, add to header field, set egress port, drop.
- Outputs modified header, verdict and done pulse to the next processor or deparser.

Parameters:
- PROC_ID, 0, processor index; reported in err/stat outputs, matches the matcher's PROC_ID.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; matcher ready_o.
- is_match_i  in  1  matcher hit flag, sampled with start_i.
- flow_val_i  in  BYTE_BUS x MAX_VAL_LEN  action record, sampled with start_i.
- pkt_hdr_i  in  BYTE_BUS x HDR_MAX_LEN  header bytes, sampled with start_i.
- parsed_hdrs_i  in  DATA_BUS x NUM_HEADERS  header start offsets.
- pkt_hdr_o  out  BYTE_BUS x HDR_MAX_LEN  modified header.
- egress_port_o  out  8  egress port.
- drop_o  out  1  drop verdict.
- err_o  out  1  field write truncated or bad opcode.
- ready_o  out  1  one-cycle done pulse; all outputs valid while ready_o=1 and held until the next start.
- mod_start_i  in  1  load miss-action config.
- mod_miss_op_i  in  8  opcode applied on miss.
- mod_miss_port_i  in  8  port used by the miss action.

Behaviour:
- Record layout (flow_val bytes):
  - [0] opcode: 0 NOP, 1 SET, 2 ADD, 3 FWD, 4 DROP
  - [1] hdr_id
  - [2] offset
  - [3] len
  - [4..] data; for FWD, [4] is the port.
- Base address = parsed_hdrs_i[hdr_id] + offset. Compute it in DECODE from the value sampled at start.
- Reset values: all outputs 0, internal regs 0, miss_op=NOP, miss_port=0, state FREE.
- Reset mid-operation aborts the operation; no ready_o pulse.
- FREE:
  - mod_start_i has priority: latch the miss config and stay in FREE.
  - Else on start_i: latch inputs, clear drop_o/err_o/ready_o, copy pkt_hdr_i into the working buffer, go to DECODE.
  - start_i while not FREE is ignored.
- DECODE (1 cycle):
  - On miss, opcode = miss_op; FWD then uses miss_port.
  - len is clamped to MAX_VAL_LEN-4; clamping sets err_o.
  - SET and ADD go to WRITE with cnt=0. All other opcodes go to DONE.
  - FWD sets egress_port_o. DROP sets drop_o.
  - Unknown opcode sets err_o and is treated as NOP.
  - SET/ADD with len=0 go to DONE.
- WRITE (one byte per cycle, len cycles):
  - SET: buf[base+cnt] = data[cnt], ascending cnt.
  - ADD: big-endian add, processed from LSB (index len-1) down to 0. 8-bit sum plus carry register; carry out of the MSB is discarded (wrap-around).
  - Any address >= HDR_MAX_LEN: write suppressed, err_o=1, counting continues.
  - After the last byte, go to DONE.
- DONE: drive pkt_hdr_o from the buffer, pulse ready_o for 1 cycle, return to FREE.
- Latency from start_i to ready_o:
  - NOP/FWD/DROP/len=0: 2 cycles.
  - SET/ADD: len+2 cycles.
- Back-to-back: a new start is accepted in the cycle ready_o is high (FSM is in FREE).

Optional Feature:
- Macro EXECUTOR_STATS_EN.
- When defined, adds three 32-bit output counters:
  - stat_hit_o and stat_miss_o increment on each accepted start.
  - stat_drop_o increments at DONE with drop_o=1.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and their logic are absent; core behaviour is identical.

Decomposition:
- Shared package / def.svh gains:
  - action opcode enum (ACT_NOP..ACT_DROP);
  - field index constants ACT_OP_IDX=0, ACT_HDR_IDX=1, ACT_OFF_IDX=2, ACT_LEN_IDX=3, ACT_DATA_IDX=4.
- Reuse existing BYTE_BUS, DATA_BUS, HDR_MAX_LEN, MAX_VAL_LEN, NUM_HEADERS.
- One natural sub-module: action_alu_byte. It is combinational; inputs op, old byte, data byte, carry_in; outputs new byte, carry_out. Keep it as a separate module for unit test.

Test Plan:
- SET, hit, parsed_hdrs[2]=14, rec {1,2,2,2,0xAB,0xCD}: ready_o at cycle 4; pkt_hdr_o[16]=AB, [17]=CD; all other bytes unchanged; err_o=0.
- ADD, hit, hdr bytes [16..17]=00 FF, rec {2,2,2,2,0x00,0x01}: result 01 00, carry propagates. With FF FF + 00 01: result 00 00, no err.
- Miss after mod_start_i (miss_op=FWD, port=7): start with is_match_i=0 gives ready_o at cycle 2, egress_port_o=7, header unchanged.
- DROP hit, then start_i asserted during the ready_o cycle: second op accepted; drop_o cleared for the second result. A start_i pulsed while in WRITE is ignored.
- Overflow: base=HDR_MAX_LEN-1, SET len=3: only the last byte written, err_o=1, latency 5.
- Reset (rst=0) asserted mid-WRITE: outputs 0 immediately, no ready_o. With EXECUTOR_STATS_EN: counters read 0, then hit=1 after one hit op.
